// File: rtl/mem_cmd_master.sv
// ---------------------------------------------------------------------------
// mem_cmd_master
//
// Bus initiator for the peripheral mem_cmd/mem_rsp bus. Takes one CPU-side
// 32-bit read or write request at a time. Address bits [15:12] are decoded
// into a one-hot peripheral select. The block issues one bus command, waits
// for read data when needed, and returns exactly one response per request.
//
// Optional build macro: MEM_CMD_TIMEOUT_EN
//   When it is defined, a read CMD that sees no mem_rsp_ready within
//   TIMEOUT_CYCLES cycles ends with an error response.
//   When it is undefined, a read waits indefinitely.
//
// Parameters
//   NR_PERIPHS      number of select lines (1..16)
//   TIMEOUT_CYCLES  read wait limit in cycles (1..65535); timeout build only
//
// Ports
//   clk            clock
//   reset_         asynchronous, active-low reset
//   cpu_req_valid  request present
//   cpu_req_ready  request accepted when valid && ready
//   cpu_req_wr     1 = write, 0 = read
//   cpu_req_addr   byte address: [15:12] peripheral index, [11:0] offset
//   cpu_req_wdata  write data
//   cpu_rsp_valid  one-cycle response strobe (no backpressure)
//   cpu_rsp_rdata  read data; 0 for writes and errors
//   cpu_rsp_err    unmapped index or timeout
//   mem_cmd_sel    one-hot peripheral select
//   mem_cmd_valid  command valid
//   mem_cmd_wr     write flag
//   mem_cmd_addr   register offset
//   mem_cmd_wdata  write data
//   mem_rsp_rdata  OR-combined read data from the responders
//   mem_rsp_ready  OR-combined read-complete flag from the responders
// ---------------------------------------------------------------------------
module mem_cmd_master #(
    parameter int NR_PERIPHS     = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset_,
    input  logic                  cpu_req_valid,
    output logic                  cpu_req_ready,
    input  logic                  cpu_req_wr,
    input  logic [31:0]           cpu_req_addr,
    input  logic [31:0]           cpu_req_wdata,
    output logic                  cpu_rsp_valid,
    output logic [31:0]           cpu_rsp_rdata,
    output logic                  cpu_rsp_err,
    output logic [NR_PERIPHS-1:0] mem_cmd_sel,
    output logic                  mem_cmd_valid,
    output logic                  mem_cmd_wr,
    output logic [11:0]           mem_cmd_addr,
    output logic [31:0]           mem_cmd_wdata,
    input  logic [31:0]           mem_rsp_rdata,
    input  logic                  mem_rsp_ready
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_RSP  = 2'd2
    } state_t;

    // Widened to 5 bits so that NR_PERIPHS = 16 still compares correctly.
    localparam logic [4:0] NR_PERIPHS_W = 5'(NR_PERIPHS);

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    state_t                  r_state;
    logic                    r_req_ready;
    logic                    r_rsp_valid;
    logic [31:0]             r_rsp_rdata;
    logic                    r_rsp_err;
    logic [NR_PERIPHS-1:0]   r_cmd_sel;
    logic                    r_cmd_valid;
    logic                    r_cmd_wr;
    logic [11:0]             r_cmd_addr;
    logic [31:0]             r_cmd_wdata;

    state_t                  w_state_next;
    logic                    w_req_ready_next;
    logic                    w_rsp_valid_next;
    logic [31:0]             w_rsp_rdata_next;
    logic                    w_rsp_err_next;
    logic [NR_PERIPHS-1:0]   w_cmd_sel_next;
    logic                    w_cmd_valid_next;
    logic                    w_cmd_wr_next;
    logic [11:0]             w_cmd_addr_next;
    logic [31:0]             w_cmd_wdata_next;

`ifdef MEM_CMD_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0]             r_wait_cnt;
    logic [15:0]             w_wait_cnt_next;
    // Only the address bits above the peripheral index are unused.
    logic                    w_unused_bits;
    assign w_unused_bits = ^cpu_req_addr[31:16];
`else
    // With no timeout, neither the upper address bits nor the limit are used.
    logic                    w_unused_bits;
    assign w_unused_bits = ^{cpu_req_addr[31:16], 16'(TIMEOUT_CYCLES)};
`endif

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic [3:0]              w_req_idx;
    logic                    w_req_mapped;
    logic                    w_handshake;
    logic [NR_PERIPHS-1:0]   w_sel_dec;

    assign w_req_idx    = cpu_req_addr[15:12];
    assign w_req_mapped = ({1'b0, w_req_idx} < NR_PERIPHS_W);
    assign w_handshake  = cpu_req_valid & r_req_ready;

    // One comparator per select line. An out-of-range index leaves every
    // line low, but that case never reaches CMD anyway.
    generate
        for (genvar gi = 0; gi < NR_PERIPHS; gi++) begin : g_sel_dec
            assign w_sel_dec[gi] = (w_req_idx == 4'(gi));
        end
    endgenerate

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        // Strobes default low. Data/command fields default to holding,
        // so they keep their value between transactions.
        w_state_next     = r_state;
        w_req_ready_next = 1'b0;
        w_rsp_valid_next = 1'b0;
        w_rsp_rdata_next = r_rsp_rdata;
        w_rsp_err_next   = r_rsp_err;
        w_cmd_sel_next   = '0;
        w_cmd_valid_next = 1'b0;
        w_cmd_wr_next    = r_cmd_wr;
        w_cmd_addr_next  = r_cmd_addr;
        w_cmd_wdata_next = r_cmd_wdata;
`ifdef MEM_CMD_TIMEOUT_EN
        w_wait_cnt_next  = r_wait_cnt;
`endif

        case (r_state)
            ST_IDLE: begin
                if (w_handshake) begin
                    if (w_req_mapped) begin
                        w_state_next     = ST_CMD;
                        w_cmd_valid_next = 1'b1;
                        w_cmd_sel_next   = w_sel_dec;
                        w_cmd_wr_next    = cpu_req_wr;
                        w_cmd_addr_next  = cpu_req_addr[11:0];
                        w_cmd_wdata_next = cpu_req_wdata;
`ifdef MEM_CMD_TIMEOUT_EN
                        w_wait_cnt_next  = 16'd0;
`endif
                    end else begin
                        // Unmapped index: answer straight away with an
                        // error and leave the bus untouched.
                        w_state_next     = ST_RSP;
                        w_rsp_valid_next = 1'b1;
                        w_rsp_err_next   = 1'b1;
                        w_rsp_rdata_next = 32'd0;
                    end
                end else begin
                    w_req_ready_next = 1'b1;
                end
            end

            ST_CMD: begin
                if (r_cmd_wr) begin
                    // A write takes exactly one command cycle; ready is
                    // not expected from responders on writes.
                    w_state_next     = ST_RSP;
                    w_rsp_valid_next = 1'b1;
                    w_rsp_err_next   = 1'b0;
                    w_rsp_rdata_next = 32'd0;
                end else if (mem_rsp_ready) begin
                    // Ready is checked before the timeout, so data that
                    // arrives in the last allowed cycle still wins.
                    w_state_next     = ST_RSP;
                    w_rsp_valid_next = 1'b1;
                    w_rsp_err_next   = 1'b0;
                    w_rsp_rdata_next = mem_rsp_rdata;
                end else begin
`ifdef MEM_CMD_TIMEOUT_EN
                    // r_wait_cnt holds (cycles in CMD - 1). When it hits
                    // TIMEOUT_LAST, this is the final permitted cycle.
                    if (r_wait_cnt == TIMEOUT_LAST) begin
                        w_state_next     = ST_RSP;
                        w_rsp_valid_next = 1'b1;
                        w_rsp_err_next   = 1'b1;
                        w_rsp_rdata_next = 32'd0;
                    end else begin
                        w_wait_cnt_next  = r_wait_cnt + 16'd1;
                        w_cmd_valid_next = 1'b1;
                        w_cmd_sel_next   = r_cmd_sel;
                    end
`else
                    w_cmd_valid_next = 1'b1;
                    w_cmd_sel_next   = r_cmd_sel;
`endif
                end
            end

            ST_RSP: begin
                w_state_next     = ST_IDLE;
                w_req_ready_next = 1'b1;
            end

            default: begin
                w_state_next     = ST_IDLE;
                w_req_ready_next = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_state     <= ST_IDLE;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= 1'b0;
            r_cmd_sel   <= '0;
            r_cmd_valid <= 1'b0;
            r_cmd_wr    <= 1'b0;
            r_cmd_addr  <= 12'd0;
            r_cmd_wdata <= 32'd0;
`ifdef MEM_CMD_TIMEOUT_EN
            r_wait_cnt  <= 16'd0;
`endif
        end else begin
            r_state     <= w_state_next;
            r_req_ready <= w_req_ready_next;
            r_rsp_valid <= w_rsp_valid_next;
            r_rsp_rdata <= w_rsp_rdata_next;
            r_rsp_err   <= w_rsp_err_next;
            r_cmd_sel   <= w_cmd_sel_next;
            r_cmd_valid <= w_cmd_valid_next;
            r_cmd_wr    <= w_cmd_wr_next;
            r_cmd_addr  <= w_cmd_addr_next;
            r_cmd_wdata <= w_cmd_wdata_next;
`ifdef MEM_CMD_TIMEOUT_EN
            r_wait_cnt  <= w_wait_cnt_next;
`endif
        end
    end

    assign cpu_req_ready = r_req_ready;
    assign cpu_rsp_valid = r_rsp_valid;
    assign cpu_rsp_rdata = r_rsp_rdata;
    assign cpu_rsp_err   = r_rsp_err;
    assign mem_cmd_sel   = r_cmd_sel;
    assign mem_cmd_valid = r_cmd_valid;
    assign mem_cmd_wr    = r_cmd_wr;
    assign mem_cmd_addr  = r_cmd_addr;
    assign mem_cmd_wdata = r_cmd_wdata;

endmodule

// File: tb/tb_mem_cmd_master.sv
// ---------------------------------------------------------------------------
// tb_mem_cmd_master
//
// Directed testbench for mem_cmd_master (NR_PERIPHS = 4, TIMEOUT_CYCLES = 8).
// The responder model asserts ready after a programmable number of
// command cycles. It can be told never to answer, and it can drive a
// stray ready outside read commands.
// ---------------------------------------------------------------------------
module tb_mem_cmd_master;

    localparam int NP = 4;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          reset_;
    logic          cpu_req_valid;
    logic          cpu_req_ready;
    logic          cpu_req_wr;
    logic [31:0]   cpu_req_addr;
    logic [31:0]   cpu_req_wdata;
    logic          cpu_rsp_valid;
    logic [31:0]   cpu_rsp_rdata;
    logic          cpu_rsp_err;
    logic [NP-1:0] mem_cmd_sel;
    logic          mem_cmd_valid;
    logic          mem_cmd_wr;
    logic [11:0]   mem_cmd_addr;
    logic [31:0]   mem_cmd_wdata;
    logic [31:0]   mem_rsp_rdata;
    logic          mem_rsp_ready;

    int tests_run    = 0;
    int tests_failed = 0;

    // Responder model controls
    int          cmd_cycles;
    int          rsp_delay  = 0;
    logic        rsp_never  = 1'b0;
    logic        rsp_stray  = 1'b0;
    logic [31:0] rsp_data   = 32'd0;

    always #5 clk = ~clk;

    mem_cmd_master #(
        .NR_PERIPHS     (NP),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk           (clk),
        .reset_        (reset_),
        .cpu_req_valid (cpu_req_valid),
        .cpu_req_ready (cpu_req_ready),
        .cpu_req_wr    (cpu_req_wr),
        .cpu_req_addr  (cpu_req_addr),
        .cpu_req_wdata (cpu_req_wdata),
        .cpu_rsp_valid (cpu_rsp_valid),
        .cpu_rsp_rdata (cpu_rsp_rdata),
        .cpu_rsp_err   (cpu_rsp_err),
        .mem_cmd_sel   (mem_cmd_sel),
        .mem_cmd_valid (mem_cmd_valid),
        .mem_cmd_wr    (mem_cmd_wr),
        .mem_cmd_addr  (mem_cmd_addr),
        .mem_cmd_wdata (mem_cmd_wdata),
        .mem_rsp_rdata (mem_rsp_rdata),
        .mem_rsp_ready (mem_rsp_ready)
    );

    // Number of completed command cycles of the current command.
    always @(posedge clk or negedge reset_) begin
        if (!reset_)
            cmd_cycles <= 0;
        else if (mem_cmd_valid)
            cmd_cycles <= cmd_cycles + 1;
        else
            cmd_cycles <= 0;
    end

    assign mem_rsp_ready = rsp_stray |
                           (mem_cmd_valid & ~mem_cmd_wr & ~rsp_never &
                            (cmd_cycles == rsp_delay));
    assign mem_rsp_rdata = mem_rsp_ready ? rsp_data : 32'd0;

    // Issues one request and follows it until the response. lat counts
    // cycles from the accept cycle up to the response cycle; -1 means no
    // response within the bound. The first command cycle's fields are
    // returned for inspection.
    task automatic run_txn(input  logic          wr,
                           input  logic [31:0]   addr,
                           input  logic [31:0]   wdata,
                           output int            lat,
                           output int            ncmd,
                           output logic [31:0]   rdata,
                           output logic          err,
                           output logic [NP-1:0] c_sel,
                           output logic [11:0]   c_addr,
                           output logic          c_wr,
                           output logic [31:0]   c_wdata);
        int  k;
        bit  done;
        lat = -1; ncmd = 0; rdata = 32'hx; err = 1'bx;
        c_sel = '0; c_addr = '0; c_wr = 1'b0; c_wdata = '0;
        @(negedge clk);
        cpu_req_valid = 1'b1;
        cpu_req_wr    = wr;
        cpu_req_addr  = addr;
        cpu_req_wdata = wdata;
        k = 0;
        while (!cpu_req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        done = 1'b0;
        for (int i = 1; i <= 60 && !done; i++) begin
            @(negedge clk);
            cpu_req_valid = 1'b0;
            if (mem_cmd_valid) begin
                if (ncmd == 0) begin
                    c_sel = mem_cmd_sel; c_addr = mem_cmd_addr;
                    c_wr = mem_cmd_wr; c_wdata = mem_cmd_wdata;
                end
                ncmd++;
            end
            if (cpu_rsp_valid) begin
                lat   = i;
                rdata = cpu_rsp_rdata;
                err   = cpu_rsp_err;
                done  = 1'b1;
            end
        end
    endtask

    task automatic apply_reset();
        reset_        = 1'b0;
        cpu_req_valid = 1'b0;
        cpu_req_wr    = 1'b0;
        cpu_req_addr  = 32'd0;
        cpu_req_wdata = 32'd0;
        repeat (3) @(negedge clk);
        reset_ = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        apply_reset();
        tests_run++;
        if (cpu_req_ready !== 1'b1 || cpu_rsp_valid !== 1'b0 || cpu_rsp_err !== 1'b0 ||
            cpu_rsp_rdata !== 32'd0 || mem_cmd_valid !== 1'b0 || mem_cmd_sel !== 4'b0000 ||
            mem_cmd_wr !== 1'b0 || mem_cmd_addr !== 12'd0 || mem_cmd_wdata !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_state: ready=%b rspv=%b err=%b rdata=%h cmdv=%b sel=%b wr=%b addr=%h wdata=%h, required ready=1 and all others 0",
                     cpu_req_ready, cpu_rsp_valid, cpu_rsp_err, cpu_rsp_rdata, mem_cmd_valid,
                     mem_cmd_sel, mem_cmd_wr, mem_cmd_addr, mem_cmd_wdata);
        end
        $display("[TB] reset: ready=%b cmd_valid=%b", cpu_req_ready, mem_cmd_valid);
    endtask

    task automatic test_write();
        int lat, ncmd; logic [31:0] rd; logic er;
        logic [NP-1:0] cs; logic [11:0] ca; logic cw; logic [31:0] cd;
        run_txn(1'b1, 32'h0000_1004, 32'h0000_005A, lat, ncmd, rd, er, cs, ca, cw, cd);
        $display("[TB] write 0x00001004: lat=%0d cmd=%0d sel=%b addr=%h err=%b", lat, ncmd, cs, ca, er);
        tests_run++;
        if (ncmd !== 1 || cs !== 4'b0010 || ca !== 12'h004 || cw !== 1'b1 || cd !== 32'h5A) begin
            tests_failed++;
            $display("FAIL write_cmd: ncmd=%0d sel=%b addr=%h wr=%b wdata=%h, required 1 0010 004 1 0000005a",
                     ncmd, cs, ca, cw, cd);
        end
        tests_run++;
        if (lat !== 2 || er !== 1'b0 || rd !== 32'd0) begin
            tests_failed++;
            $display("FAIL write_rsp: lat=%0d err=%b rdata=%h, required 2 0 00000000", lat, er, rd);
        end
        @(negedge clk);
        tests_run++;
        if (cpu_rsp_valid !== 1'b0 || cpu_req_ready !== 1'b1 || mem_cmd_valid !== 1'b0 ||
            mem_cmd_addr !== 12'h004 || mem_cmd_wdata !== 32'h5A) begin
            tests_failed++;
            $display("FAIL write_after: rspv=%b ready=%b cmdv=%b addr=%h wdata=%h, required 0 1 0 004 0000005a",
                     cpu_rsp_valid, cpu_req_ready, mem_cmd_valid, mem_cmd_addr, mem_cmd_wdata);
        end
    endtask

    task automatic test_read_comb();
        int lat, ncmd; logic [31:0] rd; logic er;
        logic [NP-1:0] cs; logic [11:0] ca; logic cw; logic [31:0] cd;
        rsp_delay = 0; rsp_data = 32'h0000_00A5;
        run_txn(1'b0, 32'h0000_0008, 32'd0, lat, ncmd, rd, er, cs, ca, cw, cd);
        $display("[TB] read 0x00000008 comb: lat=%0d cmd=%0d rdata=%h err=%b", lat, ncmd, rd, er);
        tests_run++;
        if (lat !== 2 || ncmd !== 1 || rd !== 32'hA5 || er !== 1'b0 || cs !== 4'b0001 ||
            ca !== 12'h008 || cw !== 1'b0) begin
            tests_failed++;
            $display("FAIL read_comb: lat=%0d ncmd=%0d rdata=%h err=%b sel=%b addr=%h wr=%b, required 2 1 000000a5 0 0001 008 0",
                     lat, ncmd, rd, er, cs, ca, cw);
        end
        // Response data must hold after the strobe.
        rsp_data = 32'h0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (cpu_rsp_rdata !== 32'hA5 || cpu_rsp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL rdata_hold: rdata=%h rspv=%b, required 000000a5 0", cpu_rsp_rdata, cpu_rsp_valid);
        end
    endtask

    task automatic test_read_delayed();
        int lat, ncmd; logic [31:0] rd; logic er;
        logic [NP-1:0] cs; logic [11:0] ca; logic cw; logic [31:0] cd;
        rsp_delay = 3; rsp_data = 32'h1234_5678;
        run_txn(1'b0, 32'hFFFF_3ABC, 32'd0, lat, ncmd, rd, er, cs, ca, cw, cd);
        $display("[TB] read 0xFFFF3ABC delay3: lat=%0d cmd=%0d rdata=%h err=%b", lat, ncmd, rd, er);
        tests_run++;
        if (lat !== 5 || ncmd !== 4 || rd !== 32'h1234_5678 || er !== 1'b0 ||
            cs !== 4'b1000 || ca !== 12'hABC) begin
            tests_failed++;
            $display("FAIL read_delayed: lat=%0d ncmd=%0d rdata=%h err=%b sel=%b addr=%h, required 5 4 12345678 0 1000 abc",
                     lat, ncmd, rd, er, cs, ca);
        end
        rsp_delay = 0;
    endtask

    task automatic test_unmapped();
        int lat, ncmd; logic [31:0] rd; logic er;
        logic [NP-1:0] cs; logic [11:0] ca; logic cw; logic [31:0] cd;
        logic [31:0] addrs [2];
        addrs[0] = 32'h0000_F000;
        addrs[1] = 32'h0000_4010;
        for (int i = 0; i < 2; i++) begin
            rsp_data = 32'hFFFF_FFFF;
            run_txn(1'b0, addrs[i], 32'd0, lat, ncmd, rd, er, cs, ca, cw, cd);
            $display("[TB] unmapped %h: lat=%0d cmd=%0d rdata=%h err=%b", addrs[i], lat, ncmd, rd, er);
            tests_run++;
            if (lat !== 1 || ncmd !== 0 || er !== 1'b1 || rd !== 32'd0) begin
                tests_failed++;
                $display("FAIL unmapped_%0d: lat=%0d ncmd=%0d err=%b rdata=%h, required 1 0 1 00000000",
                         i, lat, ncmd, er, rd);
            end
        end
        @(negedge clk);
        tests_run++;
        if (cpu_req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL unmapped_ready: ready=%b, required 1", cpu_req_ready);
        end
    endtask

    task automatic test_stray_ready();
        int lat, ncmd; logic [31:0] rd; logic er;
        logic [NP-1:0] cs; logic [11:0] ca; logic cw; logic [31:0] cd;
        int bad;
        bad = 0;
        rsp_stray = 1'b1; rsp_data = 32'hDEAD_BEEF;
        repeat (3) begin
            @(negedge clk);
            if (cpu_rsp_valid !== 1'b0 || mem_cmd_valid !== 1'b0) bad++;
        end
        tests_run++;
        if (bad !== 0) begin
            tests_failed++;
            $display("FAIL stray_idle: %0d cycles with activity, required 0", bad);
        end
        run_txn(1'b1, 32'h0000_2010, 32'h0000_0077, lat, ncmd, rd, er, cs, ca, cw, cd);
        rsp_stray = 1'b0;
        $display("[TB] write with stray ready: lat=%0d cmd=%0d rdata=%h err=%b", lat, ncmd, rd, er);
        tests_run++;
        if (lat !== 2 || ncmd !== 1 || rd !== 32'd0 || er !== 1'b0 || cs !== 4'b0100) begin
            tests_failed++;
            $display("FAIL stray_write: lat=%0d ncmd=%0d rdata=%h err=%b sel=%b, required 2 1 00000000 0 0100",
                     lat, ncmd, rd, er, cs);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] rdy;
        logic       cv;
        logic [NP-1:0] sel;
        @(negedge clk);
        cpu_req_valid = 1'b1; cpu_req_wr = 1'b1;
        cpu_req_addr = 32'h0000_1000; cpu_req_wdata = 32'h11;
        rdy[0] = cpu_req_ready;
        @(negedge clk);
        cpu_req_addr = 32'h0000_2000; cpu_req_wdata = 32'h22;
        rdy[1] = cpu_req_ready;
        @(negedge clk);
        rdy[2] = cpu_req_ready;
        @(negedge clk);
        rdy[3] = cpu_req_ready;
        @(negedge clk);
        cpu_req_valid = 1'b0;
        cv = mem_cmd_valid; sel = mem_cmd_sel;
        $display("[TB] back-to-back: ready seq=%b second sel=%b", rdy, sel);
        tests_run++;
        if (rdy !== 4'b1001) begin
            tests_failed++;
            $display("FAIL b2b_ready: seq(c3..c0)=%b, required 1001", rdy);
        end
        tests_run++;
        if (cv !== 1'b1 || sel !== 4'b0100 || mem_cmd_wdata !== 32'h22) begin
            tests_failed++;
            $display("FAIL b2b_second_cmd: valid=%b sel=%b wdata=%h, required 1 0100 00000022",
                     cv, sel, mem_cmd_wdata);
        end
        repeat (2) @(negedge clk);
    endtask

`ifdef MEM_CMD_TIMEOUT_EN
    task automatic test_timeout();
        int lat, ncmd; logic [31:0] rd; logic er;
        logic [NP-1:0] cs; logic [11:0] ca; logic cw; logic [31:0] cd;
        rsp_never = 1'b1;
        run_txn(1'b0, 32'h0000_1020, 32'd0, lat, ncmd, rd, er, cs, ca, cw, cd);
        rsp_never = 1'b0;
        $display("[TB] timeout no ready: lat=%0d cmd=%0d rdata=%h err=%b", lat, ncmd, rd, er);
        tests_run++;
        if (ncmd !== 8 || lat !== 9 || er !== 1'b1 || rd !== 32'd0) begin
            tests_failed++;
            $display("FAIL timeout_err: ncmd=%0d lat=%0d err=%b rdata=%h, required 8 9 1 00000000",
                     ncmd, lat, er, rd);
        end
        rsp_delay = 7; rsp_data = 32'hCAFE_0001;
        run_txn(1'b0, 32'h0000_1020, 32'd0, lat, ncmd, rd, er, cs, ca, cw, cd);
        rsp_delay = 0;
        $display("[TB] timeout ready in last cycle: lat=%0d cmd=%0d rdata=%h err=%b", lat, ncmd, rd, er);
        tests_run++;
        if (ncmd !== 8 || lat !== 9 || er !== 1'b0 || rd !== 32'hCAFE_0001) begin
            tests_failed++;
            $display("FAIL timeout_last_ready: ncmd=%0d lat=%0d err=%b rdata=%h, required 8 9 0 cafe0001",
                     ncmd, lat, er, rd);
        end
    endtask
`else
    task automatic test_long_wait();
        int lat, ncmd; logic [31:0] rd; logic er;
        logic [NP-1:0] cs; logic [11:0] ca; logic cw; logic [31:0] cd;
        rsp_delay = 20; rsp_data = 32'h0BAD_F00D;
        run_txn(1'b0, 32'h0000_1020, 32'd0, lat, ncmd, rd, er, cs, ca, cw, cd);
        rsp_delay = 0;
        $display("[TB] long read wait: lat=%0d cmd=%0d rdata=%h err=%b", lat, ncmd, rd, er);
        tests_run++;
        if (ncmd !== 21 || lat !== 22 || er !== 1'b0 || rd !== 32'h0BAD_F00D) begin
            tests_failed++;
            $display("FAIL long_wait: ncmd=%0d lat=%0d err=%b rdata=%h, required 21 22 0 0badf00d",
                     ncmd, lat, er, rd);
        end
    endtask
`endif

    task automatic test_reset_mid_read();
        int lat, ncmd; logic [31:0] rd; logic er;
        logic [NP-1:0] cs; logic [11:0] ca; logic cw; logic [31:0] cd;
        int seen_rsp;
        rsp_never = 1'b1;
        @(negedge clk);
        cpu_req_valid = 1'b1; cpu_req_wr = 1'b0; cpu_req_addr = 32'h0000_3000;
        @(negedge clk);
        cpu_req_valid = 1'b0;
        @(negedge clk);
        tests_run++;
        if (mem_cmd_valid !== 1'b1 || mem_cmd_sel !== 4'b1000) begin
            tests_failed++;
            $display("FAIL mid_read_cmd: valid=%b sel=%b, required 1 1000", mem_cmd_valid, mem_cmd_sel);
        end
        #2 reset_ = 1'b0;
        #1;
        $display("[TB] reset mid-read: cmd_valid=%b sel=%b rsp_valid=%b ready=%b",
                 mem_cmd_valid, mem_cmd_sel, cpu_rsp_valid, cpu_req_ready);
        tests_run++;
        if (mem_cmd_valid !== 1'b0 || mem_cmd_sel !== 4'b0000 || cpu_rsp_valid !== 1'b0 ||
            cpu_req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_async: cmdv=%b sel=%b rspv=%b ready=%b, required 0 0000 0 1",
                     mem_cmd_valid, mem_cmd_sel, cpu_rsp_valid, cpu_req_ready);
        end
        rsp_never = 1'b0;
        @(negedge clk);
        reset_ = 1'b1;
        seen_rsp = 0;
        repeat (3) begin
            @(negedge clk);
            if (cpu_rsp_valid !== 1'b0 || mem_cmd_valid !== 1'b0) seen_rsp++;
        end
        tests_run++;
        if (seen_rsp !== 0 || cpu_req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_dropped: activity cycles=%0d ready=%b, required 0 1", seen_rsp, cpu_req_ready);
        end
        run_txn(1'b1, 32'h0000_0100, 32'h0000_0033, lat, ncmd, rd, er, cs, ca, cw, cd);
        $display("[TB] write after reset: lat=%0d cmd=%0d sel=%b err=%b", lat, ncmd, cs, er);
        tests_run++;
        if (lat !== 2 || ncmd !== 1 || cs !== 4'b0001 || ca !== 12'h100 || er !== 1'b0 || rd !== 32'd0) begin
            tests_failed++;
            $display("FAIL post_reset_write: lat=%0d ncmd=%0d sel=%b addr=%h err=%b rdata=%h, required 2 1 0001 100 0 00000000",
                     lat, ncmd, cs, ca, er, rd);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_comb();
        test_read_delayed();
        test_unmapped();
        test_stray_ready();
        test_back_to_back();
`ifdef MEM_CMD_TIMEOUT_EN
        test_timeout();
`else
        test_long_wait();
`endif
        test_reset_mid_read();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
